// File: rtl/sd_multiblock_controller.sv
// ---------------------------------------------------------------------------
// sd_multiblock_controller
//
// Top-level sequencer for the SPI-mode SD card path. After reset it runs card
// initialisation. It then services multi-block write and read requests from
// the bulk engine, one block at a time. It enables exactly one sub-controller
// (init / write / read) and muxes that sub-controller's command frame and chip
// select onto the shared SPI shifter. The card address advances per block.
// A block or an initialisation that stalls for TIMEOUT_CYCLES aborts through
// a one-cycle ERROR state, and the card is then re-initialised.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   write_req, read_req        request levels, sampled only in IDLE
//   start_addr, block_count    request parameters, sampled with the request
//   block_addressing           1 = SDHC (+1 per block), 0 = SDSC (+512)
//   init_status, blk_status    sub-controller done pulses
//   *_command, *_cs            sub-controller frames and chip selects
//   init/write/read_enable     sub-controller enables
//   blk_addr                   address of the current block
//   command, cs, divider       muxed SPI shifter controls (divider=1: slow SCLK)
//   busy, spi_init_done        status levels
//   transfer_done/_error       one-cycle completion / abort pulses
//   blocks_done                blocks completed in the current/last request
// ---------------------------------------------------------------------------
module sd_multiblock_controller #(
  parameter int CMD_W          = 48,
  parameter int ADDR_W         = 32,
  parameter int MAX_BLOCKS     = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CNT_W         = $clog2(MAX_BLOCKS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_req,
  input  logic              read_req,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  block_count,
  input  logic              block_addressing,
  input  logic              init_status,
  input  logic              blk_status,
  input  logic [CMD_W-1:0]  init_command,
  input  logic [CMD_W-1:0]  write_command,
  input  logic [CMD_W-1:0]  read_command,
  input  logic              init_cs,
  input  logic              write_cs,
  input  logic              read_cs,
  output logic              init_enable,
  output logic              write_enable,
  output logic              read_enable,
  output logic [ADDR_W-1:0] blk_addr,
  output logic [CMD_W-1:0]  command,
  output logic              cs,
  output logic              divider,
  output logic              busy,
  output logic              spi_init_done,
  output logic              transfer_done,
  output logic              transfer_error,
  output logic [CNT_W-1:0]  blocks_done
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_WRITE, ST_READ, ST_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [ADDR_W-1:0]  blk_addr_q, blk_addr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   blocks_done_q, blocks_done_d;
  logic               gap_q, gap_d;
  logic               spi_init_done_q, spi_init_done_d;
  logic               transfer_done_q, transfer_done_d;
  logic               transfer_error_q, transfer_error_d;

  logic               timeout;
  logic               blk_ok;
  logic [CNT_W-1:0]   req_count;
  logic [ADDR_W-1:0]  addr_step;

  assign timeout   = (timer_q == TO_W'(TIMEOUT_CYCLES - 1));
  // A block completes only while its sub-controller is actually enabled.
  assign blk_ok    = blk_status && !gap_q &&
                     (state_q == ST_WRITE || state_q == ST_READ);
  assign req_count = (block_count > CNT_W'(MAX_BLOCKS)) ? CNT_W'(MAX_BLOCKS)
                                                        : block_count;
  assign addr_step = block_addressing ? ADDR_W'(1) : ADDR_W'(512);

  // Next-state and register update logic.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d          = state_q;
    blk_addr_d       = blk_addr_q;
    remaining_d      = remaining_q;
    blocks_done_d    = blocks_done_q;
    gap_d            = 1'b0;
    spi_init_done_d  = spi_init_done_q;
    transfer_done_d  = 1'b0;
    transfer_error_d = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (init_status) begin
          state_d         = ST_IDLE;
          spi_init_done_d = 1'b1;
        end else if (timeout) begin
          state_d          = ST_ERROR;
          transfer_error_d = 1'b1;
          spi_init_done_d  = 1'b0;
        end
      end
      ST_IDLE: begin
        if (write_req || read_req) begin
          blk_addr_d    = start_addr;
          remaining_d   = req_count;
          blocks_done_d = '0;
          if (req_count == '0) transfer_done_d = 1'b1;
          else state_d = write_req ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE, ST_READ: begin
        // blk_status is checked before timeout so it wins a same-cycle tie.
        if (blk_ok) begin
          blocks_done_d = blocks_done_q + 1'b1;
          blk_addr_d    = blk_addr_q + addr_step;
          remaining_d   = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d         = ST_IDLE;
            transfer_done_d = 1'b1;
          end else begin
            gap_d = 1'b1;
          end
        end else if (timeout) begin
          state_d          = ST_ERROR;
          transfer_error_d = 1'b1;
          spi_init_done_d  = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (state_d != state_q || blk_ok || state_q == ST_IDLE) timer_d = '0;
    else                                                    timer_d = timer_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_INIT;
      timer_q          <= '0;
      blk_addr_q       <= '0;
      remaining_q      <= '0;
      blocks_done_q    <= '0;
      gap_q            <= 1'b0;
      spi_init_done_q  <= 1'b0;
      transfer_done_q  <= 1'b0;
      transfer_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      blk_addr_q       <= blk_addr_d;
      remaining_q      <= remaining_d;
      blocks_done_q    <= blocks_done_d;
      gap_q            <= gap_d;
      spi_init_done_q  <= spi_init_done_d;
      transfer_done_q  <= transfer_done_d;
      transfer_error_q <= transfer_error_d;
    end
  end

  // Moore output decode from the registered state.
  always_comb begin
    init_enable  = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    divider      = 1'b0;
    command      = '0;
    cs           = 1'b1;
    case (state_q)
      ST_INIT: begin
        init_enable = 1'b1;
        divider     = 1'b1;
        command     = init_command;
        cs          = init_cs;
      end
      ST_WRITE: begin
        write_enable = !gap_q;
        command      = write_command;
        cs           = write_cs;
      end
      ST_READ: begin
        read_enable = !gap_q;
        command     = read_command;
        cs          = read_cs;
      end
      default: ;
    endcase
  end

  assign busy           = (state_q != ST_IDLE);
  assign blk_addr       = blk_addr_q;
  assign blocks_done    = blocks_done_q;
  assign spi_init_done  = spi_init_done_q;
  assign transfer_done  = transfer_done_q;
  assign transfer_error = transfer_error_q;

endmodule

// File: tb/tb_sd_multiblock_controller.sv
// ---------------------------------------------------------------------------
// tb_sd_multiblock_controller
//
// Directed bench for sd_multiblock_controller with TIMEOUT_CYCLES=32. Inputs
// change 1 ns after a rising edge and outputs are checked at that point, so
// every check sees the state registered by the preceding edge.
// ---------------------------------------------------------------------------
module tb_sd_multiblock_controller;

  localparam int CMD_W  = 48;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              write_req = 1'b0;
  logic              read_req = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [CNT_W-1:0]  block_count = '0;
  logic              block_addressing = 1'b1;
  logic              init_status = 1'b0;
  logic              blk_status = 1'b0;
  logic [CMD_W-1:0]  init_command  = 48'h40_0000_0000_95;
  logic [CMD_W-1:0]  write_command = 48'h59_0000_0100_FF;
  logic [CMD_W-1:0]  read_command  = 48'h52_0000_0000_FF;
  logic              init_cs  = 1'b0;
  logic              write_cs = 1'b0;
  logic              read_cs  = 1'b1;
  logic              init_enable, write_enable, read_enable;
  logic [ADDR_W-1:0] blk_addr;
  logic [CMD_W-1:0]  command;
  logic              cs, divider, busy, spi_init_done;
  logic              transfer_done, transfer_error;
  logic [CNT_W-1:0]  blocks_done;

  int checks = 0;
  int errors = 0;

  sd_multiblock_controller #(
    .CMD_W(CMD_W), .ADDR_W(ADDR_W), .MAX_BLOCKS(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst),
    .write_req(write_req), .read_req(read_req),
    .start_addr(start_addr), .block_count(block_count),
    .block_addressing(block_addressing),
    .init_status(init_status), .blk_status(blk_status),
    .init_command(init_command), .write_command(write_command),
    .read_command(read_command),
    .init_cs(init_cs), .write_cs(write_cs), .read_cs(read_cs),
    .init_enable(init_enable), .write_enable(write_enable),
    .read_enable(read_enable),
    .blk_addr(blk_addr), .command(command), .cs(cs), .divider(divider),
    .busy(busy), .spi_init_done(spi_init_done),
    .transfer_done(transfer_done), .transfer_error(transfer_error),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_blk();
    blk_status = 1'b1;
    tick();
    blk_status = 1'b0;
  endtask

  initial begin
    // ---------------- reset and initialisation ----------------
    tick();
    tick();
    rst = 1'b0;
    check("rst_init_en",   64'(init_enable),   64'd1);
    check("rst_divider",   64'(divider),       64'd1);
    check("rst_busy",      64'(busy),          64'd1);
    check("rst_init_done", 64'(spi_init_done), 64'd0);
    check("rst_blk_addr",  64'(blk_addr),      64'd0);
    check("rst_blocks",    64'(blocks_done),   64'd0);
    check("rst_done",      64'(transfer_done), 64'd0);
    check("rst_error",     64'(transfer_error),64'd0);
    check("init_cmd_mux",  64'(command),       64'(init_command));
    check("init_cs_mux",   64'(cs),            64'd0);
    repeat (18) tick();
    init_status = 1'b1;
    tick();
    init_status = 1'b0;
    check("init_done",     64'(spi_init_done), 64'd1);
    check("idle_busy",     64'(busy),          64'd0);
    check("idle_init_en",  64'(init_enable),   64'd0);
    check("idle_divider",  64'(divider),       64'd0);
    check("idle_cs",       64'(cs),            64'd1);
    check("idle_cmd",      64'(command),       64'd0);

    // ---------------- write 3 blocks, SDHC, both requests high ----------------
    write_req = 1'b1; read_req = 1'b1;
    start_addr = 32'h100; block_count = 5'd3; block_addressing = 1'b1;
    tick();
    write_req = 1'b0; read_req = 1'b0;
    start_addr = 32'hDEAD;
    check("wr_enable",     64'(write_enable),  64'd1);
    check("wr_no_rd_en",   64'(read_enable),   64'd0);
    check("wr_addr0",      64'(blk_addr),      64'h100);
    check("wr_cmd_mux",    64'(command),       64'(write_command));
    check("wr_cs_mux",     64'(cs),            64'd0);
    check("wr_divider",    64'(divider),       64'd0);
    repeat (3) tick();
    pulse_blk();
    check("wr_gap1",       64'(write_enable),  64'd0);
    check("wr_addr1",      64'(blk_addr),      64'h101);
    check("wr_blocks1",    64'(blocks_done),   64'd1);
    tick();
    check("wr_reen1",      64'(write_enable),  64'd1);
    tick();
    pulse_blk();
    check("wr_gap2",       64'(write_enable),  64'd0);
    check("wr_addr2",      64'(blk_addr),      64'h102);
    tick();
    check("wr_reen2",      64'(write_enable),  64'd1);
    pulse_blk();
    check("wr_done",       64'(transfer_done), 64'd1);
    check("wr_done_busy",  64'(busy),          64'd0);
    check("wr_blocks3",    64'(blocks_done),   64'd3);
    check("wr_addr_end",   64'(blk_addr),      64'h103);
    check("wr_en_off",     64'(write_enable),  64'd0);
    tick();
    check("wr_done_pulse", 64'(transfer_done), 64'd0);

    // ---------------- read 2 blocks, SDSC ----------------
    read_req = 1'b1; start_addr = 32'h0; block_count = 5'd2;
    block_addressing = 1'b0;
    tick();
    read_req = 1'b0;
    check("rd_enable",     64'(read_enable),   64'd1);
    check("rd_no_wr_en",   64'(write_enable),  64'd0);
    check("rd_addr0",      64'(blk_addr),      64'd0);
    check("rd_cs_hi",      64'(cs),            64'd1);
    check("rd_cmd_mux",    64'(command),       64'(read_command));
    read_cs = 1'b0; read_command = 48'h51_0000_0200_FF;
    #1;
    check("rd_cs_track",   64'(cs),            64'd0);
    check("rd_cmd_track",  64'(command),       64'h51_0000_0200_FF);
    pulse_blk();
    check("rd_addr1",      64'(blk_addr),      64'd512);
    check("rd_gap",        64'(read_enable),   64'd0);
    tick();
    pulse_blk();
    check("rd_done",       64'(transfer_done), 64'd1);
    check("rd_blocks",     64'(blocks_done),   64'd2);
    check("rd_addr_end",   64'(blk_addr),      64'd1024);

    // ---------------- blk_status in IDLE is ignored ----------------
    pulse_blk();
    check("idle_blk_ign",  64'(blocks_done),   64'd2);
    check("idle_blk_busy", 64'(busy),          64'd0);

    // ---------------- block_count = 0 ----------------
    write_req = 1'b1; block_count = 5'd0; start_addr = 32'h55;
    tick();
    write_req = 1'b0;
    check("zero_done",     64'(transfer_done), 64'd1);
    check("zero_busy",     64'(busy),          64'd0);
    check("zero_no_en",    64'(write_enable),  64'd0);
    check("zero_blocks",   64'(blocks_done),   64'd0);
    tick();
    check("zero_pulse",    64'(transfer_done), 64'd0);

    // ---------------- clamp 31 -> 16 blocks, address wrap ----------------
    write_req = 1'b1; block_count = 5'd31; start_addr = 32'hFFFF_FFF8;
    block_addressing = 1'b1;
    tick();
    write_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pulse_blk();
      if (i < 15) begin
        if (i == 14) check("clamp_not_done", 64'(transfer_done), 64'd0);
        tick();
      end
    end
    check("clamp_done",    64'(transfer_done), 64'd1);
    check("clamp_blocks",  64'(blocks_done),   64'd16);
    check("wrap_addr",     64'(blk_addr),      64'h8);

    // ---------------- timeout with no blk_status ----------------
    read_req = 1'b1; block_count = 5'd2; start_addr = 32'h0;
    tick();
    read_req = 1'b0;
    repeat (31) tick();
    check("to_still_rd",   64'(read_enable),   64'd1);
    check("to_no_err_yet", 64'(transfer_error),64'd0);
    tick();
    check("to_error",      64'(transfer_error),64'd1);
    check("to_init_clr",   64'(spi_init_done), 64'd0);
    check("to_rd_off",     64'(read_enable),   64'd0);
    check("to_cs",         64'(cs),            64'd1);
    check("to_busy",       64'(busy),          64'd1);
    tick();
    check("to_reinit",     64'(init_enable),   64'd1);
    check("to_err_pulse",  64'(transfer_error),64'd0);
    check("to_divider",    64'(divider),       64'd1);
    init_status = 1'b1;
    tick();
    init_status = 1'b0;
    check("reinit_done",   64'(spi_init_done), 64'd1);

    // ---------------- blk_status wins over timeout, then reset mid-transfer ----
    write_req = 1'b1; block_count = 5'd4; start_addr = 32'h40;
    tick();
    write_req = 1'b0;
    repeat (31) tick();
    pulse_blk();
    check("tie_no_error",  64'(transfer_error),64'd0);
    check("tie_blocks",    64'(blocks_done),   64'd1);
    check("tie_busy",      64'(busy),          64'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_init_en",  64'(init_enable),   64'd1);
    check("mrst_wr_off",   64'(write_enable),  64'd0);
    check("mrst_blocks",   64'(blocks_done),   64'd0);
    check("mrst_addr",     64'(blk_addr),      64'd0);
    check("mrst_no_done",  64'(transfer_done), 64'd0);
    check("mrst_no_err",   64'(transfer_error),64'd0);
    check("mrst_init_clr", 64'(spi_init_done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_multiblock_controller.md
# sd_multiblock_controller

Top-level sequencer for the SPI-mode SD card path: runs card initialisation after reset, then services multi-block read and write requests from the USB-side bulk engine. It drives per-mode enables to the initialisation, write and read sub-controllers. It muxes their command and chip-select outputs onto the shared SPI shifter, advances the card address block by block, and aborts any block that stalls past a timeout, then re-initialises the card.

## Interface
- CMD_W, 48, width of an SD SPI command frame
- ADDR_W, 32, card address width
- MAX_BLOCKS, 16, largest block count per request
- TIMEOUT_CYCLES, 65535, clk cycles allowed per block or for initialisation
- CNT_W = $clog2(MAX_BLOCKS+1) (derived, not overridable)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- write_req  in  1  start multi-block write (level, sampled in IDLE)
- read_req  in  1  start multi-block read (level, sampled in IDLE)
- start_addr  in  ADDR_W  first card address, sampled with request
- block_count  in  CNT_W  blocks to transfer, sampled with request
- block_addressing  in  1  1 = SDHC (address +1 per block), 0 = SDSC (address +512)
- init_status  in  1  init sub-controller done pulse
- blk_status  in  1  write/read sub-controller one-block-done pulse
- init_command / write_command / read_command  in  CMD_W  sub-controller frames
- init_cs / write_cs / read_cs  in  1  sub-controller chip selects (active low)
- init_enable / write_enable / read_enable  out  1  sub-controller enables
- blk_addr  out  ADDR_W  address of the current block
- command  out  CMD_W  muxed frame to the shifter
- cs  out  1  muxed chip select
- divider  out  1  1 = slow SCLK (init only)
- busy  out  1  state is not IDLE
- spi_init_done  out  1  high from first init completion until reset/error
- transfer_done  out  1  one-cycle pulse, request completed
- transfer_error  out  1  one-cycle pulse, timeout abort
- blocks_done  out  CNT_W  blocks completed in current/last request

## Operation
- States: INIT, IDLE, WRITE, READ, ERROR. Reset state INIT.
- INIT: init_enable=1, divider=1, command/cs from init_*. init_status -> IDLE, spi_init_done<=1. Timeout -> ERROR.
- IDLE: cs=1, command=0, all enables 0. write_req wins over read_req when both high. On accept: blk_addr<=start_addr, remaining<=block_count, blocks_done<=0.
- block_count=0: no transition to WRITE/READ; transfer_done pulses next cycle, state stays IDLE.
- block_count>MAX_BLOCKS: clamped to MAX_BLOCKS.
- WRITE/READ: matching enable=1, command/cs from matching sub-controller. Each blk_status: blocks_done+1, blk_addr += (block_addressing ? 1 : 512), remaining-1, timeout counter cleared. Last block -> IDLE with transfer_done pulse.
- Enable is deasserted for exactly one cycle after each non-final blk_status so the sub-controller restarts from its idle state.
- Timeout counter: cleared on state entry and on each blk_status; reaching TIMEOUT_CYCLES-1 -> ERROR.
- ERROR: one cycle, all enables 0, cs=1, transfer_error pulse, spi_init_done<=0, then INIT.
- blk_addr arithmetic wraps modulo 2^ADDR_W with no flag.
- blk_status or init_status outside the matching state is ignored.
- Requests arriving while busy are ignored; they are not queued.

## Timing
- Reset values: state INIT, blk_addr 0, blocks_done 0, spi_init_done 0, transfer_done 0, transfer_error 0. busy 1 and init_enable 1 from the first cycle after reset.
- Enables, command, cs and divider decode combinationally from the registered state (Moore). Pulses and counters are registered.
- Request accepted at edge N: enable high from cycle N+1.
- Final blk_status at edge M: state IDLE and transfer_done=1 in cycle M+1, busy=0 in the same cycle.
- rst mid-transfer: returns to INIT on the next edge and clears all counters. No done or error pulse.
- Timeout and blk_status in the same cycle: blk_status wins.

## Test plan
- Reset -> init_enable=1, divider=1. Pulse init_status at cycle 20 -> spi_init_done=1 and busy=0 at cycle 21.
- write_req, start_addr=0x100, block_count=3, block_addressing=1. Three blk_status pulses -> blk_addr 0x100/0x101/0x102, enable gaps of one cycle, transfer_done one cycle after the third pulse, blocks_done=3.
- read_req, start_addr=0, block_count=2, block_addressing=0 -> blk_addr 0 then 512. cs and command track read_cs and read_command. write_fifo path unaffected.
- write_req and read_req both high in IDLE -> WRITE entered. block_count=0 -> transfer_done pulse with no enable.
- TIMEOUT_CYCLES=32, no blk_status -> ERROR after 32 cycles, transfer_error pulse, spi_init_done=0, re-enter INIT.
- rst asserted during block 2 of 4 -> INIT next cycle, blocks_done=0, no transfer_done or transfer_error pulse.
